// File: rtl/rs_issue_sched.sv
// Age-ordered dual-port issue scheduler: picks the two oldest ready RS entries
// relative to the ROB head and registers them into per-port output stages.
module rs_issue_sched #(
    parameter int RS_SIZE   = 16,
    parameter int ROB_IDX_W = 5,
    parameter int RS_IDX_W  = $clog2(RS_SIZE)
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                squash,
    input  logic [RS_SIZE-1:0]                  entry_ready,
    input  logic [RS_SIZE-1:0][ROB_IDX_W-1:0]   entry_rob_idx,
    input  logic [ROB_IDX_W-1:0]                rob_head,
    input  logic [1:0]                          port_ready,
    output logic [RS_SIZE-1:0]                  grant,
    output logic [1:0]                          port_valid,
    output logic [1:0][RS_IDX_W-1:0]            port_rs_idx,
    output logic [1:0][ROB_IDX_W-1:0]           port_rob_idx
);

    logic [RS_SIZE-1:0][ROB_IDX_W-1:0] entryAge;
    logic                              firstFound;
    logic [RS_IDX_W-1:0]               firstIdx;
    logic [ROB_IDX_W-1:0]              firstAge;
    logic                              secondFound;
    logic [RS_IDX_W-1:0]               secondIdx;
    logic [ROB_IDX_W-1:0]              secondAge;
    logic [1:0]                        portFree;
    logic [1:0]                        assignValid;
    logic [1:0][RS_IDX_W-1:0]          assignIdx;

    logic [1:0]                        portValid_q, portValid_d;
    logic [1:0][RS_IDX_W-1:0]          portRsIdx_q, portRsIdx_d;
    logic [1:0][ROB_IDX_W-1:0]         portRobIdx_q, portRobIdx_d;

    // Modular distance from the ROB head; the subtraction wraps at ROB_IDX_W bits.
    always_comb begin
        for (int i = 0; i < RS_SIZE; i++) begin
            entryAge[i] = entry_rob_idx[i] - rob_head;
        end
    end

    // Strict less-than while scanning upward keeps the lower index on equal age.
    always_comb begin
        firstFound = 1'b0;
        firstIdx   = '0;
        firstAge   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (entry_ready[i] && (!firstFound || (entryAge[i] < firstAge))) begin
                firstFound = 1'b1;
                firstIdx   = RS_IDX_W'(i);
                firstAge   = entryAge[i];
            end
        end
    end

    always_comb begin
        secondFound = 1'b0;
        secondIdx   = '0;
        secondAge   = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            if (entry_ready[i] && !(firstFound && (RS_IDX_W'(i) == firstIdx)) &&
                (!secondFound || (entryAge[i] < secondAge))) begin
                secondFound = 1'b1;
                secondIdx   = RS_IDX_W'(i);
                secondAge   = entryAge[i];
            end
        end
    end

    // Oldest goes to the lowest free port, second-oldest to the next free one.
    always_comb begin
        portFree    = ~portValid_q | port_ready;
        assignValid = '0;
        assignIdx   = '0;
        if (!reset && !squash) begin
            if (portFree[0]) begin
                assignValid[0] = firstFound;
                assignIdx[0]   = firstIdx;
                if (portFree[1]) begin
                    assignValid[1] = secondFound;
                    assignIdx[1]   = secondIdx;
                end
            end else if (portFree[1]) begin
                assignValid[1] = firstFound;
                assignIdx[1]   = firstIdx;
            end
        end
    end

    always_comb begin
        grant = '0;
        for (int p = 0; p < 2; p++) begin
            if (assignValid[p]) begin
                grant[assignIdx[p]] = 1'b1;
            end
        end
    end

    // Load beats drain beats hold; squash clears both stages regardless of stall.
    always_comb begin
        portValid_d  = portValid_q;
        portRsIdx_d  = portRsIdx_q;
        portRobIdx_d = portRobIdx_q;
        for (int p = 0; p < 2; p++) begin
            if (squash) begin
                portValid_d[p]  = 1'b0;
                portRsIdx_d[p]  = '0;
                portRobIdx_d[p] = '0;
            end else if (assignValid[p]) begin
                portValid_d[p]  = 1'b1;
                portRsIdx_d[p]  = assignIdx[p];
                portRobIdx_d[p] = entry_rob_idx[assignIdx[p]];
            end else if (port_ready[p]) begin
                portValid_d[p]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            portValid_q  <= '0;
            portRsIdx_q  <= '0;
            portRobIdx_q <= '0;
        end else begin
            portValid_q  <= portValid_d;
            portRsIdx_q  <= portRsIdx_d;
            portRobIdx_q <= portRobIdx_d;
        end
    end

    assign port_valid   = portValid_q;
    assign port_rs_idx  = portRsIdx_q;
    assign port_rob_idx = portRobIdx_q;

endmodule
